// File: rtl/bf_data_responder_pkg.sv
// Shared encodings for the Brainfuck data-memory responder: bus direction and FSM state codes.
package bf_data_responder_pkg;

    localparam logic DIRECTION_READ  = 1'b0;
    localparam logic DIRECTION_WRITE = 1'b1;

    localparam logic [2:0] RSTATE_CLEAR  = 3'd0;
    localparam logic [2:0] RSTATE_IDLE   = 3'd1;
    localparam logic [2:0] RSTATE_WAIT   = 3'd2;
    localparam logic [2:0] RSTATE_ACCESS = 3'd3;
    localparam logic [2:0] RSTATE_HOLD   = 3'd4;

    typedef logic [7:0] tape_byte_t;

endpackage

// File: rtl/bf_data_responder_if.sv
// CPU data-memory handshake bus: the core is the master (initiator), the tape RAM block the slave.
interface bf_data_if #(
    parameter int D_ADDR_WIDTH = 8
) ();
    import bf_data_responder_pkg::*;

    logic                    d_req;
    logic                    d_dir;
    logic [D_ADDR_WIDTH-1:0] d_addr;
    tape_byte_t              d_wdata;
    logic                    d_ack;
    tape_byte_t              d_rdata;

    modport master (
        output d_req, d_dir, d_addr, d_wdata,
        input  d_ack, d_rdata
    );

    modport slave (
        input  d_req, d_dir, d_addr, d_wdata,
        output d_ack, d_rdata
    );

endinterface

// File: rtl/bf_data_responder_byte_ram.sv
// Byte-wide tape RAM: one posedge write port and one registered read port.
module bf_byte_ram
    import bf_data_responder_pkg::*;
#(
    parameter int D_ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [D_ADDR_WIDTH-1:0] waddr,
    input  tape_byte_t              wdata,
    input  logic [D_ADDR_WIDTH-1:0] raddr,
    output tape_byte_t              rdata
);

    localparam int DEPTH = 2 ** D_ADDR_WIDTH;

    tape_byte_t mem [DEPTH];

    // NOTE: the array has no reset branch so it maps onto block RAM; zeroing is done by the clear sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/bf_data_responder.sv
// Responder end of the CPU d_* handshake: owns the tape RAM, inserts wait states, sweeps the tape to zero after reset.
module bf_data_responder
    import bf_data_responder_pkg::*;
#(
    parameter int D_ADDR_WIDTH   = 8,
    parameter int WAIT_CYCLES    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    bf_data_if.slave bus,
    output logic     ready,
    output logic     proto_err
);

    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES - 1);
    localparam logic       DO_CLEAR = (CLEAR_ON_RESET != 0);

    logic [2:0]              state;
    logic [7:0]              cnt;
    logic [D_ADDR_WIDTH-1:0] ptr;
    logic                    ack_q;
    tape_byte_t              rdata_q;

    logic                    dir_q;
    logic [D_ADDR_WIDTH-1:0] addr_q;
    tape_byte_t              wdata_q;

    logic                    ram_we;
    logic [D_ADDR_WIDTH-1:0] ram_waddr;
    tape_byte_t              ram_wdata;
    logic [D_ADDR_WIDTH-1:0] ram_raddr;
    tape_byte_t              ram_q;

    assign bus.d_ack   = ack_q;
    assign bus.d_rdata = rdata_q;

    // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ptr;
        ram_wdata = '0;
        if (state == RSTATE_CLEAR) begin
            ram_we = 1'b1;
        end else if (state == RSTATE_ACCESS && bus.d_req && dir_q == DIRECTION_WRITE) begin
            ram_we    = 1'b1;
            ram_waddr = addr_q;
            ram_wdata = wdata_q;
        end
    end

    // Read address comes straight off the bus at capture so the registered RAM output is valid by ACCESS
    // even with zero wait states; afterwards it tracks the captured address.
    assign ram_raddr = (state == RSTATE_IDLE) ? bus.d_addr : addr_q;

    bf_byte_ram #(
        .D_ADDR_WIDTH (D_ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // Request registers are pure datapath, only meaningful after a capture, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == RSTATE_IDLE && bus.d_req) begin
            dir_q   <= bus.d_dir;
            addr_q  <= bus.d_addr;
            wdata_q <= bus.d_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= DO_CLEAR ? RSTATE_CLEAR : RSTATE_IDLE;
            ready     <= !DO_CLEAR;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            proto_err <= 1'b0;
            cnt       <= '0;
            ptr       <= '0;
        end else begin
            case (state)
                RSTATE_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == '1) begin
                        ready <= 1'b1;
                        state <= RSTATE_IDLE;
                    end
                end
                RSTATE_IDLE: begin
                    if (bus.d_req) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= RSTATE_ACCESS;
                        end else begin
                            cnt   <= WAIT_INIT;
                            state <= RSTATE_WAIT;
                        end
                    end
                end
                RSTATE_WAIT: begin
                    if (!bus.d_req) begin
                        proto_err <= 1'b1;
                        state     <= RSTATE_IDLE;
                    end else if (cnt == 8'd0) begin
                        state <= RSTATE_ACCESS;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RSTATE_ACCESS: begin
                    if (!bus.d_req) begin
                        proto_err <= 1'b1;
                        state     <= RSTATE_IDLE;
                    end else begin
                        if (dir_q == DIRECTION_READ) begin
                            rdata_q <= ram_q;
                        end
                        ack_q <= 1'b1;
                        state <= RSTATE_HOLD;
                    end
                end
                RSTATE_HOLD: begin
                    if (!bus.d_req) begin
                        ack_q <= 1'b0;
                        state <= RSTATE_IDLE;
                    end
                end
                default: begin
                    state <= RSTATE_IDLE;
                end
            endcase
        end
    end

endmodule
